frame_renderer: RTL

Responder to the game datapath's screen-update request in the JOSH Jump design. On a request, it latches the dude position and sweeps the 120x100 playfield column by column. For each column it reads the wall bitmap through a synchronous read port, then issues one plot command per pixel to the VGA adapter write port. It asserts `done` when the frame is complete.

---
 rtl/frame_renderer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/frame_renderer.sv
// Column-by-column playfield renderer: reads one wall column per sweep, then plots each
// pixel of that column with dude/wall colours. Optional RENDER_BORDER_EN paints the field edge red.
module frame_renderer #(
  parameter int FIELD_W = 120,
  parameter int FIELD_H = 100,
  parameter int DUDE_W  = 4,
  parameter int DUDE_H  = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic [6:0]         hdude,
  input  logic [7:0]         vdude,
  output logic [6:0]         wall_addr,
  input  logic [FIELD_H-1:0] wall_rdata,
  output logic               busy,
  output logic               done,
  output logic [7:0]         x_out,
  output logic [6:0]         y_out,
  output logic [2:0]         colour,
  output logic               plot
);

  localparam logic [6:0] LAST_COL = 7'(FIELD_W - 1);
  localparam logic [6:0] LAST_ROW = 7'(FIELD_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLOT, S_DONE} state_t;

  state_t             state;
  logic [6:0]         col, row;
  logic [6:0]         hd_q;
  logic [7:0]         vd_q;
  logic [FIELD_H-1:0] col_bits;

  // Outputs are registered, so colour is computed for the row about to be presented.
  logic [6:0] nxt_row;
  logic       nxt_wall, in_dude;
  logic [2:0] nxt_colour;
  logic [8:0] col9, row9, hd9, vd9;

  always_comb begin
    nxt_row  = (state == S_PLOT) ? row + 7'd1 : 7'd0;
    nxt_wall = (state == S_PLOT) ? col_bits[nxt_row] : wall_rdata[nxt_row];
    col9     = {2'b0, col};
    row9     = {2'b0, nxt_row};
    hd9      = {2'b0, hd_q};
    vd9      = {1'b0, vd_q};
    // 9-bit bounds so a sprite near the field edge never wraps back in.
    in_dude  = (col9 >= hd9) && (col9 < hd9 + 9'(DUDE_W)) &&
               (row9 >= vd9) && (row9 < vd9 + 9'(DUDE_H));
    if (in_dude)
      nxt_colour = 3'b111;
`ifdef RENDER_BORDER_EN
    else if (col == 7'd0 || col == LAST_COL || nxt_row == 7'd0 || nxt_row == LAST_ROW)
      nxt_colour = 3'b100;
`endif
    else if (nxt_wall)
      nxt_colour = 3'b010;
    else
      nxt_colour = 3'b000;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      hd_q      <= '0;
      vd_q      <= '0;
      col_bits  <= '0;
      wall_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      colour    <= '0;
      plot      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          hd_q      <= hdude;
          vd_q      <= vdude;
          col       <= '0;
          wall_addr <= '0;
          busy      <= 1'b1;
          state     <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          col_bits <= wall_rdata;
          row      <= '0;
          plot     <= 1'b1;
          x_out    <= {1'b0, col};
          y_out    <= '0;
          colour   <= nxt_colour;
          state    <= S_PLOT;
        end
        S_PLOT: begin
          if (row == LAST_ROW) begin
            plot <= 1'b0;
            if (col == LAST_COL) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              col       <= col + 7'd1;
              wall_addr <= col + 7'd1;
              state     <= S_FETCH;
            end
          end else begin
            row    <= nxt_row;
            y_out  <= nxt_row;
            colour <= nxt_colour;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
